// File: rtl/counter_pkg.sv
// Shared definitions for the sweep-sequencing counter: controller state encoding
// and step-direction constants.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/updn_cnt6.sv
// Loadable up/down counter, WIDTH bits, wrapping modulo 2^WIDTH.
// A load takes priority over a count step.
module updn_cnt6
    import counter_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= data;
        end else if (en) begin
            r_count <= (up_down == UP) ? r_count + 1'b1 : r_count - 1'b1;
        end
    end

    assign count = r_count;

endmodule : updn_cnt6

// File: rtl/counter_seq_ctrl.sv
// Sweep sequencer: accepts a start/end/direction/repeat command and drives an
// up/down counter through reps+1 sweeps, with pause, abort and a done pulse.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int REPW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             cmd_dir,
    input  logic [REPW-1:0]  cmd_reps,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic [REPW-1:0]  sweep_idx,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_end;
    logic             r_dir;
    logic [REPW-1:0]  r_reps;
    logic [REPW-1:0]  r_sweep_idx;

    logic             w_accept;
    logic             w_load;
    logic             w_en;
    logic             w_sweep_inc;
    logic             w_done;
    logic [WIDTH-1:0] w_count;

    updn_cnt6 #(
        .WIDTH   (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .data    (r_start),
        .en      (w_en),
        .up_down (r_dir),
        .count   (w_count)
    );

    // NOTE: every signal driven here gets a default first, so no path through the
    // case statement can leave a value unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_sweep_inc  = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid && !abort) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over pause; pause also masks the terminal-match test.
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (!pause) begin
                    if (w_count != r_end) begin
                        w_en = 1'b1;
                    end else if (r_sweep_idx == r_reps) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_sweep_inc  = 1'b1;
                        w_next_state = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                w_done       = !abort;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_start     <= '0;
            r_end       <= '0;
            r_dir       <= DOWN;
            r_reps      <= '0;
            r_sweep_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_start     <= cmd_start;
                r_end       <= cmd_end;
                r_dir       <= cmd_dir;
                r_reps      <= cmd_reps;
                r_sweep_idx <= '0;
            end else if (w_sweep_inc) begin
                r_sweep_idx <= r_sweep_idx + 1'b1;
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE) && !abort;
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign done      = w_done;
    assign count     = w_count;
    assign sweep_idx = r_sweep_idx;

endmodule : counter_seq_ctrl

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: the driver expands each command into the
// expected per-cycle trace of outputs, and a negedge monitor compares every busy/done cycle.
module tb_counter_seq_ctrl;
    import counter_pkg::*;

    localparam int WIDTH = 6;
    localparam int REPW  = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_end;
    logic             cmd_dir;
    logic [REPW-1:0]  cmd_reps;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic [REPW-1:0]  sweep_idx;
    logic             busy;
    logic             done;

    typedef struct {
        int count;
        int sweep;
        bit busy;
        bit done;
        bit pause;
        bit run;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   sb_en    = 1'b1;
    int   m_count  = 0;

    counter_seq_ctrl #(
        .WIDTH     (WIDTH),
        .REPW      (REPW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .cmd_dir   (cmd_dir),
        .cmd_reps  (cmd_reps),
        .pause     (pause),
        .abort     (abort),
        .count     (count),
        .sweep_idx (sweep_idx),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic ent_t mk(int c, int s, bit b, bit d, bit p, bit r);
        ent_t e;
        e.count = c; e.sweep = s; e.busy = b; e.done = d; e.pause = p; e.run = r;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && sb_en && (busy || done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_activity", {30'd0, busy, done}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("busy", busy, mon_e.busy);
                check("done", done, mon_e.done);
                check("count", count, mon_e.count);
                check("sweep_idx", sweep_idx, mon_e.sweep);
                check("cmd_ready_busy", cmd_ready, 0);
            end
        end
    end

    // pmode: 0 none, 1 random, 2 three-cycle pause at the first count of 4.
    // amode: 0 none, 1 random point, 2 at the first RUN cycle showing 5.
    task automatic run_cmd(input int st, input int en, input bit dir, input int reps,
                           input int pmode, input int amode);
        ent_t tr[$];
        int   cur, len, c, np, cut, final_c;
        bit   paused_once;
        cur = m_count;
        paused_once = 1'b0;
        for (int s = 0; s <= reps; s++) begin
            tr.push_back(mk(cur, s, 1, 0, (pmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 0));
            len = dir ? (((en - st) % MOD + MOD) % MOD) + 1 : (((st - en) % MOD + MOD) % MOD) + 1;
            for (int k = 0; k < len; k++) begin
                c = dir ? (st + k) % MOD : (st - k + MOD) % MOD;
                np = 0;
                if (pmode == 1 && $urandom_range(0, 7) == 0) np = $urandom_range(1, 3);
                if (pmode == 2 && c == 4 && !paused_once) begin
                    np = 3;
                    paused_once = 1'b1;
                end
                for (int p = 0; p < np; p++) tr.push_back(mk(c, s, 1, 0, 1, 1));
                tr.push_back(mk(c, s, 1, 0, 0, 1));
            end
            cur = en;
        end
        tr.push_back(mk(en, reps, 0, 1, (pmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 0));

        cut = -1;
        if (amode == 1) begin
            cut = $urandom_range(0, tr.size() - 2);
        end else if (amode == 2) begin
            for (int i = 0; i < tr.size(); i++)
                if (cut < 0 && tr[i].run && !tr[i].pause && tr[i].count == 5) cut = i;
        end
        if (cut >= 0) begin
            while (tr.size() > cut + 1) void'(tr.pop_back());
            final_c = tr[cut].count;
        end else begin
            final_c = en;
        end

        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_start = WIDTH'(st);
        cmd_end   = WIDTH'(en);
        cmd_dir   = dir;
        cmd_reps  = REPW'(reps);
        pause     = 1'($urandom_range(0, 1));
        abort     = 1'b0;
        @(posedge clk); #1;

        foreach (tr[i]) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_start = WIDTH'($urandom);
            cmd_end   = WIDTH'($urandom);
            cmd_dir   = 1'($urandom);
            cmd_reps  = REPW'($urandom);
            pause     = (i == cut) ? 1'($urandom_range(0, 1)) : tr[i].pause;
            abort     = (i == cut);
            exp_q.push_back(tr[i]);
            @(posedge clk); #1;
        end

        cmd_valid = 1'b0;
        abort     = 1'b0;
        pause     = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_ready", cmd_ready, 1);
        check("idle_count", count, final_c);
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
        m_count = final_c;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_end   = '0;
        cmd_dir   = DOWN;
        cmd_reps  = '0;
        pause     = 1'b0;
        abort     = 1'b0;
        #17;
        check("rst_count", count, 0);
        check("rst_sweep_idx", sweep_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", cmd_ready, 1);

        run_cmd(3, 6, UP, 0, 0, 0);
        run_cmd(62, 1, UP, 0, 0, 0);
        run_cmd(1, 62, DOWN, 2, 0, 0);
        run_cmd(5, 5, UP, 0, 0, 0);
        run_cmd(3, 6, UP, 0, 2, 0);
        run_cmd(3, 6, UP, 0, 0, 2);

        // Abort in IDLE blocks acceptance even with a valid command present.
        cmd_valid = 1'b1;
        cmd_start = 6'd20;
        cmd_end   = 6'd22;
        cmd_dir   = UP;
        abort     = 1'b1;
        @(negedge clk);
        check("abort_idle_ready", cmd_ready, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        check("abort_idle_not_busy", busy, 0);
        check("abort_idle_count", count, m_count);
        @(posedge clk); #1;

        // Reset mid-RUN takes effect without a clock edge.
        sb_en     = 1'b0;
        cmd_valid = 1'b1;
        cmd_start = 6'd10;
        cmd_end   = 6'd40;
        cmd_dir   = UP;
        cmd_reps  = 4'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_count", count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sweep_idx", sweep_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_count = 0;
        @(posedge clk); #1;
        check("ready_after_midrst", cmd_ready, 1);
        sb_en = 1'b1;

        for (int n = 0; n < 40; n++) begin
            run_cmd($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), 1,
                    ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_counter_seq_ctrl

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter WIDTH SHALL default to 6 and set the counter/data width in bits.
REQ-002 Parameter REPW SHALL default to 4 and set the repeat-count width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_start  input  WIDTH  sweep start value.
REQ-008 cmd_end  input  WIDTH  sweep end (terminal) value.
REQ-009 cmd_dir  input  1  step direction: 1 = up (+1), 0 = down (-1).
REQ-010 cmd_reps  input  REPW  extra sweeps; total sweeps SHALL be cmd_reps+1.
REQ-011 pause  input  1  freeze the sequence while in RUN.
REQ-012 abort  input  1  synchronous cancel of the current sequence.
REQ-013 count  output  WIDTH  live counter value.
REQ-014 sweep_idx  output  REPW  index of the current sweep, 0-based.
REQ-015 busy  output  1  high in LOAD and RUN.
REQ-016 done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN and DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE with abort=0; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-019 On acceptance, start/end/dir/reps SHALL be captured into internal registers; sweep_idx SHALL be set to 0; the next state SHALL be LOAD.
REQ-020 Command inputs SHALL be ignored outside the accept cycle.
REQ-021 LOAD SHALL last one cycle and load count with the captured start; the next state SHALL be RUN.
REQ-022 In RUN with pause=0 and count != end, count SHALL step by ±1 per cycle, modulo 2^WIDTH (63+1 -> 0; 0-1 -> 63).
REQ-023 In RUN with pause=0 and count == end, count SHALL hold (no step) and the current sweep SHALL be complete.
REQ-024 On sweep completion, if sweep_idx == reps the next state SHALL be DONE.
REQ-025 On sweep completion, if sweep_idx != reps, sweep_idx SHALL increment and the next state SHALL be LOAD.
REQ-026 A sweep SHALL therefore occupy ((end-start) mod 2^WIDTH)+1 RUN cycles going up, and ((start-end) mod 2^WIDTH)+1 going down.
REQ-027 start == end SHALL complete the sweep on the first RUN cycle.
REQ-028 pause=1 in RUN SHALL hold count, sweep_idx and state, and SHALL suppress the terminal-match evaluation; pause SHALL have no effect in other states.
REQ-029 DONE SHALL last one cycle with done=1; the next state SHALL be IDLE; count SHALL retain end.
REQ-030 abort=1 in LOAD, RUN or DONE SHALL force IDLE on the next edge, hold count, and produce no done pulse.
REQ-031 abort SHALL take priority over pause, over terminal match and over command acceptance.
REQ-032 Latency: a command accepted at cycle T SHALL put the FSM in LOAD at T+1, and count SHALL equal start at T+2.

Reset
REQ-033 While rst_n=0: state SHALL be IDLE; count, sweep_idx and all captured registers SHALL be 0; busy=0; done=0; cmd_ready SHALL be 1 once rst_n=1.
REQ-034 Reset asserted mid-sequence SHALL take effect immediately, without waiting for clk, and SHALL not generate done.

Structure
REQ-035 The FSM state encoding and the direction constants (UP=1, DOWN=0) SHALL live in the shared package counter_pkg.
REQ-036 The counter datapath SHALL be one sub-module, updn_cnt6, a WIDTH-parameterised counter with ports clk, rst_n, load, data, en and up_down, and output count.
REQ-037 The controller SHALL drive updn_cnt6 through load, data, en and up_down only.

Verification
REQ-038 start=3, end=6, up, reps=0, accepted at cycle 0 -> count 3,4,5,6 at cycles 2-5; done=1 at cycle 6; cmd_ready=1 at cycle 7.
REQ-039 start=62, end=1, up, reps=0 -> count 62,63,0,1, then done.
REQ-040 start=1, end=62, down, reps=2 -> three sweeps 1,0,63,62 with sweep_idx 0,1,2; a LOAD cycle between sweeps; done asserted once.
REQ-041 start=end=5, reps=0 -> a single RUN cycle with count=5, done at cycle 3.
REQ-042 pause held 3 cycles while count=4 in REQ-038 -> count stays 4 for those 3 cycles, and done moves 3 cycles later.
REQ-043 abort at count=5 in REQ-038 -> IDLE next cycle with count=5 and no done; rst_n pulsed low mid-RUN -> count=0 and IDLE immediately.
